// File: rtl/payload_char_decoder_pkg.sv
// Shared definitions for the payload decoder and the NFA engine generator: lane count,
// character-class membership masks and decoder FSM state codes.
package payload_engine_pkg;

    localparam int unsigned LANES               = 8;
    localparam int unsigned NUM_CLASSES_DEFAULT = 64;

    localparam logic [2:0] StIdle   = 3'd0;
    localparam logic [2:0] StSod    = 3'd1;
    localparam logic [2:0] StStream = 3'd2;
    localparam logic [2:0] StFlush  = 3'd3;
    localparam logic [2:0] StEop    = 3'd4;

    typedef logic [NUM_CLASSES_DEFAULT-1:0][255:0] class_mask_t;

    // Classes: 0-25 letters (case-folded), 26-35 single digits, 36 digit, 37 letter,
    // 38 whitespace, 39-47 "/.:=?&%-_", 48 any, 49 hex, 50 non-printable, 51-63 "<>'\"();,+*@#!".
    function automatic logic class_member(int unsigned k, logic [7:0] b);
        logic [7:0] lc;
        logic       digit;
        lc    = b | 8'h20;
        digit = (b >= 8'h30) && (b <= 8'h39);
        if (k < 26) return lc == 8'(32'h61 + k);
        if (k < 36) return b == 8'(32'h30 + k - 26);
        case (k)
            36: return digit;
            37: return (lc >= 8'h61) && (lc <= 8'h7a);
            38: return (b == 8'h20) || (b == 8'h09) || (b == 8'h0a) || (b == 8'h0d);
            39: return b == 8'h2f;
            40: return b == 8'h2e;
            41: return b == 8'h3a;
            42: return b == 8'h3d;
            43: return b == 8'h3f;
            44: return b == 8'h26;
            45: return b == 8'h25;
            46: return b == 8'h2d;
            47: return b == 8'h5f;
            48: return 1'b1;
            49: return digit || ((lc >= 8'h61) && (lc <= 8'h66));
            50: return (b < 8'h20) || (b >= 8'h7f);
            51: return b == 8'h3c;
            52: return b == 8'h3e;
            53: return b == 8'h27;
            54: return b == 8'h22;
            55: return b == 8'h28;
            56: return b == 8'h29;
            57: return b == 8'h3b;
            58: return b == 8'h2c;
            59: return b == 8'h2b;
            60: return b == 8'h2a;
            61: return b == 8'h40;
            62: return b == 8'h23;
            63: return b == 8'h21;
            default: return 1'b0;
        endcase
    endfunction

    function automatic class_mask_t build_class_masks();
        class_mask_t m;
        m = '0;
        for (int unsigned k = 0; k < NUM_CLASSES_DEFAULT; k++) begin
            for (int unsigned b = 0; b < 256; b++) begin
                m[k][b] = class_member(k, 8'(b));
            end
        end
        return m;
    endfunction

    localparam class_mask_t CLASS_MASK = build_class_masks();

endpackage

// File: rtl/payload_char_decoder_if.sv
// AXI4-Stream payload input bundle feeding payload_char_decoder.
interface payload_char_decoder_if
    import payload_engine_pkg::*;
#(
    parameter int unsigned DATA_W = LANES * 8
);
    logic [DATA_W-1:0]   tdata;
    logic [DATA_W/8-1:0] tkeep;
    logic                tvalid;
    logic                tlast;
    logic                tready;

    modport master (output tdata, output tkeep, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tkeep, input tvalid, input tlast, output tready);
endinterface

// File: rtl/payload_char_decoder_char_class_lut.sv
// Combinational byte to character-class hit vector, read straight out of CLASS_MASK.
module char_class_lut
    import payload_engine_pkg::*;
#(
    parameter int unsigned NUM_CLASSES = NUM_CLASSES_DEFAULT
) (
    input  logic [7:0]             byte_i,
    output logic [NUM_CLASSES-1:0] hit_o
);
    always_comb begin
        hit_o = '0;
        for (int k = 0; k < NUM_CLASSES; k++) begin
            hit_o[k] = CLASS_MASK[k][byte_i];
        end
    end
endmodule

// File: rtl/payload_char_decoder.sv
// Serialises AXI4-Stream payload words to one byte per clock, decodes class lines and drives
// the shared engine sod/en/eop controls. Optional byte limit: PAYLOAD_DEPTH_LIMIT_EN.
module payload_char_decoder
    import payload_engine_pkg::*;
#(
    parameter int unsigned DATA_W      = LANES * 8,
    parameter int unsigned NUM_CLASSES = NUM_CLASSES_DEFAULT
`ifdef PAYLOAD_DEPTH_LIMIT_EN
    ,
    parameter int unsigned MAX_DEPTH   = 1460
`endif
) (
    input  logic                   clk,
    input  logic                   rst,
    payload_char_decoder_if.slave  s_axis,
    output logic [NUM_CLASSES-1:0] class_hit,
    output logic                   en,
    output logic                   sod,
    output logic                   eop,
    output logic [7:0]             byte_out
);
    localparam int unsigned Lanes = DATA_W / 8;
    localparam int unsigned LaneW = (Lanes > 1) ? $clog2(Lanes) : 1;
    localparam logic [LaneW-1:0] LastLane = LaneW'(Lanes - 1);

    logic [2:0]             state_q, state_d;
    logic [LaneW-1:0]       lane_q, lane_d;
    logic                   hold_q, hold_d;
    logic [Lanes-1:0][7:0]  data_q, data_d;
    logic [Lanes-1:0]       keep_q, keep_d;
    logic                   last_q, last_d;
    logic                   tready_q, tready_d;
    logic                   en_q, en_d, sod_q, sod_d, eop_q, eop_d;
    logic [NUM_CLASSES-1:0] class_hit_q, class_hit_d;
    logic [7:0]             byte_out_q, byte_out_d;
    logic                   hs, load, emit, kept, fire, depth_ok;
    logic [7:0]             cur_byte;
    logic [NUM_CLASSES-1:0] lut_hit;

    assign hs = s_axis.tvalid && tready_q;

    always_comb begin
        state_d = state_q;
        lane_d  = lane_q;
        hold_d  = hold_q;
        load    = 1'b0;
        case (state_q)
            StIdle: begin
                if (hs) begin
                    load    = 1'b1;
                    state_d = StSod;
                end
            end
            StSod: begin
                state_d = StStream;
                lane_d  = '0;
                hold_d  = 1'b0;
            end
            StStream: begin
                if (lane_q != LastLane) begin
                    lane_d = lane_q + LaneW'(1);
                end else if (last_q) begin
                    state_d = StFlush;
                end else if (hs) begin
                    load   = 1'b1;
                    lane_d = '0;
                    hold_d = 1'b0;
                end else begin
                    // Word drained, next not yet offered: idle the engines but stay ready.
                    hold_d = 1'b1;
                end
            end
            StFlush: state_d = StEop;
            StEop: begin
                if (hs) begin
                    load    = 1'b1;
                    state_d = StSod;
                end else begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        data_d = load ? s_axis.tdata : data_q;
        keep_d = load ? s_axis.tkeep : keep_q;
        last_d = load ? s_axis.tlast : last_q;
    end

    assign cur_byte = data_d[lane_d];

    char_class_lut #(
        .NUM_CLASSES(NUM_CLASSES)
    ) u_lut (
        .byte_i(cur_byte),
        .hit_o (lut_hit)
    );

    // Outputs are decoded from next-state values so every port comes straight off a flop.
    always_comb begin
        emit        = (state_d == StStream) && !hold_d;
        kept        = emit && keep_d[lane_d];
        fire        = kept && depth_ok;
        tready_d    = (state_d == StIdle) || (state_d == StEop) ||
                      ((state_d == StStream) && (lane_d == LastLane) && !last_d);
        sod_d       = (state_d == StSod);
        eop_d       = (state_d == StEop);
        en_d        = fire || (state_d == StFlush);
        class_hit_d = fire ? lut_hit : '0;
        byte_out_d  = emit ? cur_byte : 8'h00;
    end

`ifdef PAYLOAD_DEPTH_LIMIT_EN
    logic [15:0] depth_q, depth_d;

    assign depth_ok = depth_q < 16'(MAX_DEPTH);

    always_comb begin
        depth_d = depth_q;
        if (state_d == StSod) begin
            depth_d = '0;
        end else if (kept && (depth_q != 16'hffff)) begin
            depth_d = depth_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) depth_q <= '0;
        else     depth_q <= depth_d;
    end
`else
    assign depth_ok = 1'b1;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            lane_q      <= '0;
            hold_q      <= 1'b0;
            data_q      <= '0;
            keep_q      <= '0;
            last_q      <= 1'b0;
            tready_q    <= 1'b0;
            en_q        <= 1'b0;
            sod_q       <= 1'b0;
            eop_q       <= 1'b0;
            class_hit_q <= '0;
            byte_out_q  <= '0;
        end else begin
            state_q     <= state_d;
            lane_q      <= lane_d;
            hold_q      <= hold_d;
            data_q      <= data_d;
            keep_q      <= keep_d;
            last_q      <= last_d;
            tready_q    <= tready_d;
            en_q        <= en_d;
            sod_q       <= sod_d;
            eop_q       <= eop_d;
            class_hit_q <= class_hit_d;
            byte_out_q  <= byte_out_d;
        end
    end

    assign s_axis.tready = tready_q;
    assign en            = en_q;
    assign sod           = sod_q;
    assign eop           = eop_q;
    assign class_hit     = class_hit_q;
    assign byte_out      = byte_out_q;
endmodule

// File: doc/payload_char_decoder.md
Name: payload_char_decoder

Overview:
- Upstream feeder for the per-rule NFA payload engines.
- Takes the 64-bit AXI4-Stream payload, serialises it to one byte per clock and decodes each byte into one-hot character-class lines (the in_N inputs of every engine).
- Generates the shared sod (engine clear), en (byte strobe) and eop (result-sample) controls.
- One instance fans out to all engines in the payload_engine core.

Parameters:
- DATA_W, 64, s_axis data width; LANES = DATA_W/8.
- NUM_CLASSES, 64, number of character-class lines driven; class k is defined by CLASS_MASK[k] in the package.
- MAX_DEPTH, 1460, payload byte limit (used only with DEPTH_LIMIT_EN).

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous, active-high reset
- s_axis_tdata  in  DATA_W  payload word, byte lane 0 = first byte
- s_axis_tkeep  in  LANES  byte-valid per lane
- s_axis_tvalid  in  1  word valid
- s_axis_tlast  in  1  last word of packet
- s_axis_tready  out  1  word accepted when tvalid&&tready
- class_hit  out  NUM_CLASSES  one-hot/multi-hot class lines for the current byte
- en  out  1  byte strobe to engines (CE of all engine flops)
- sod  out  1  start-of-data pulse, drives engine CLR
- eop  out  1  end-of-packet pulse; engine outputs are valid this cycle
- byte_out  out  8  current byte (debug/trace)

Behaviour:
- Clock and reset: single clock clk; rst is asynchronous, active-high.
- Reset values: all outputs 0, including s_axis_tready; FSM in IDLE, lane counter 0.
- Registered outputs: all outputs are registered (glitch-free sod is mandatory, since it is an async clear downstream).
- FSM states: IDLE, SOD, STREAM, FLUSH, EOP.
- IDLE: tready=1. On tvalid, latch data/keep/last and go to SOD.
- SOD (1 cycle): port sod=1, en=0, class_hit=0. Then STREAM with lane=0.
  - sod and en are never high in the same cycle.
- STREAM (one lane per cycle, lane 0..LANES-1):
  - en=tkeep[lane]; class_hit=decode(byte[lane]) when kept, else 0; byte_out=byte[lane].
  - Port-level latency: first byte appears 2 cycles after the accepting handshake.
  - At lane=LANES-1 with latched last=0: tready=1.
    - If tvalid: load the next word with no bubble (lane wraps to 0).
    - Else: hold in STREAM with en=0 and tready=1 until tvalid.
  - At lane=LANES-1 with last=1: go to FLUSH.
- FLUSH (1 cycle): en=1, class_hit=0, sod=0.
  - Lets each engine's sticky end state capture a match on the final byte; all other engine states clear.
- EOP (1 cycle): eop=1, en=0. Downstream samples engine out here.
  - tready=1; a word accepted in this cycle goes to SOD, giving back-to-back packets with 3 idle-byte cycles.
- tkeep rules:
  - Sparse tkeep is legal; unkept lanes still take a cycle with en=0.
  - tkeep=0 with tlast still gives FLUSH and EOP.
  - A single-word empty packet gives sod, 8×en=0, flush, eop.
- tvalid drop: tvalid dropping mid-packet leaves class_hit=0 and en=0 during waits.
- Reset mid-packet: everything clears immediately, no eop. Upstream shares rst, so the next accepted word is the start of a new packet.
- Decode: class_hit[k] = CLASS_MASK[k][byte]. The CLASS_MASK table encodes case folding and ranges.

Optional Feature:
- Macro: PAYLOAD_DEPTH_LIMIT_EN.
- Defined: a 16-bit byte counter, cleared in SOD, counts kept bytes. Bytes beyond MAX_DEPTH are consumed at full rate with en=0; FLUSH/EOP are unchanged.
- Undefined: no counter; every kept byte produces en=1.

Decomposition:
- Package payload_engine_pkg holds:
  - LANES;
  - NUM_CLASSES default;
  - CLASS_MASK array of 256-bit membership masks, shared with the engine generator;
  - FSM state enum.
- Sub-module char_class_lut: combinational byte → NUM_CLASSES hit vector from CLASS_MASK, registered in the parent.

Test Plan:
- Single word "/logos.g", tkeep=FF, tlast=1 → sod at T+1; en=1 for 8 cycles at T+2..T+9 with the '/' class at T+2 and 'l' (L-class) at T+3; flush en=1/class_hit=0 at T+10; eop at T+11.
- Two-word packet, second word tkeep=0x07, tlast=1 → 11 en=1 cycles, 5 en=0 lane cycles, then flush and eop; no bubble between words when tvalid is held.
- tvalid deasserted 4 cycles between words → en=0 and class_hit=0 for exactly 4 wait cycles; byte order preserved.
- rst asserted mid-STREAM at lane 3 → all outputs 0 asynchronously, no eop; the next packet starts with sod.
- Back-to-back packets with tvalid held high → second handshake in the EOP cycle, second sod in the following cycle; sod never coincides with en.
- With PAYLOAD_DEPTH_LIMIT_EN and MAX_DEPTH=10 on a 16-byte packet → en=1 for exactly 10 bytes, then 6 en=0 cycles, flush, eop.
